// File: rtl/frame_loader.sv
// Packs an 8-bit pixel stream into 16-bit words and writes them sequentially
// into the framebuffer RAM. Pulses frame_done once the last word is stored.
module frame_loader #(
  parameter logic [13:0] BASE_ADDR = 14'h0000,
  parameter int          NUM_WORDS = 8192
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        wr_en,
  output logic [13:0] wr_addr,
  output logic [15:0] wr_data,
  output logic        busy,
  output logic        frame_done,
  output logic [13:0] word_count
);

  typedef enum logic [2:0] {IDLE, GET_LO, GET_HI, WRITE, DONE} state_t;

  localparam logic [13:0] LAST_WORD = 14'(NUM_WORDS - 1);

  state_t      state_reg, state_next;
  logic [7:0]  lo_reg, lo_next;
  logic [13:0] addr_reg, addr_next;
  logic [13:0] count_reg, count_next;
  logic [15:0] data_reg, data_next;
  logic        ready_next, wr_en_next, busy_next, done_next;
  logic        transfer;

  assign transfer   = pix_valid && pix_ready;
  assign wr_addr    = addr_reg;
  assign wr_data    = data_reg;
  assign word_count = count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      lo_reg     <= 8'h00;
      addr_reg   <= BASE_ADDR;
      count_reg  <= 14'd0;
      data_reg   <= 16'h0000;
      pix_ready  <= 1'b0;
      wr_en      <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_reg  <= state_next;
      lo_reg     <= lo_next;
      addr_reg   <= addr_next;
      count_reg  <= count_next;
      data_reg   <= data_next;
      pix_ready  <= ready_next;
      wr_en      <= wr_en_next;
      busy       <= busy_next;
      frame_done <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    lo_next    = lo_reg;
    addr_next  = addr_reg;
    count_next = count_reg;
    data_next  = data_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          addr_next  = BASE_ADDR;
          count_next = 14'd0;
          state_next = GET_LO;
        end
      end
      GET_LO: begin
        if (abort) begin
          state_next = IDLE;
        end else if (transfer) begin
          lo_next    = pix_data;
          state_next = GET_HI;
        end
      end
      GET_HI: begin
        // abort drops the latched low byte; the pair is never written
        if (abort) begin
          state_next = IDLE;
        end else if (transfer) begin
          data_next  = {pix_data, lo_reg};
          state_next = WRITE;
        end
      end
      WRITE: begin
        // The write presented this cycle always lands, even under abort
        count_next = count_reg + 14'd1;
        if (abort) begin
          state_next = IDLE;
        end else if (count_reg == LAST_WORD) begin
          state_next = DONE;
        end else begin
          addr_next  = addr_reg + 14'd1;
          state_next = GET_LO;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Registered outputs decode the state being entered
    ready_next = (state_next == GET_LO) || (state_next == GET_HI);
    wr_en_next = (state_next == WRITE);
    busy_next  = (state_next != IDLE);
    done_next  = (state_next == DONE);
  end

endmodule

// File: tb/tb_frame_loader.sv
// Scoreboard bench for frame_loader: one instance with a 4-word frame at
// address 0, one with a 2-word frame at the top of the address space.
module tb_frame_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        abort = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [7:0]  pix_data = 8'h00;
  logic        pix_valid = 1'b0;

  logic        pix_ready_a, wr_en_a, busy_a, frame_done_a;
  logic [13:0] wr_addr_a, word_count_a;
  logic [15:0] wr_data_a;
  logic        pix_ready_b, wr_en_b, busy_b, frame_done_b;
  logic [13:0] wr_addr_b, word_count_b;
  logic [15:0] wr_data_b;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt_a = 0, done_cnt_b = 0;
  logic prev_wr_a = 1'b0, prev_wr_b = 1'b0;

  logic [29:0] q_a[$];
  logic [29:0] q_b[$];
  bit          sel = 1'b0;
  logic [13:0] exp_addr;
  logic [7:0]  lo_val;
  bit          lo_pending;

  always #5 clk = ~clk;

  frame_loader #(.BASE_ADDR(14'h0000), .NUM_WORDS(4)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready_a),
    .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
    .busy(busy_a), .frame_done(frame_done_a), .word_count(word_count_a)
  );

  frame_loader #(.BASE_ADDR(14'h3FFE), .NUM_WORDS(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready_b),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .busy(busy_b), .frame_done(frame_done_b), .word_count(word_count_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Scoreboard side: every observed write must match the oldest pushed pair
  always @(negedge clk) begin
    logic [29:0] e;
    if (wr_en_a) begin
      if (q_a.size() == 0) check("a_extra_write", 32'd1, 32'd0);
      else begin
        e = q_a.pop_front();
        check("a_wr_addr", 32'(wr_addr_a), 32'(e[29:16]));
        check("a_wr_data", 32'(wr_data_a), 32'(e[15:0]));
      end
      check("a_ready_in_write", 32'(pix_ready_a), 32'd0);
    end
    if (frame_done_a) begin
      done_cnt_a++;
      check("a_done_after_wr", 32'(prev_wr_a), 32'd1);
    end
    prev_wr_a = wr_en_a;
    if (wr_en_b) begin
      if (q_b.size() == 0) check("b_extra_write", 32'd1, 32'd0);
      else begin
        e = q_b.pop_front();
        check("b_wr_addr", 32'(wr_addr_b), 32'(e[29:16]));
        check("b_wr_data", 32'(wr_data_b), 32'(e[15:0]));
      end
      check("b_ready_in_write", 32'(pix_ready_b), 32'd0);
    end
    if (frame_done_b) begin
      done_cnt_b++;
      check("b_done_after_wr", 32'(prev_wr_b), 32'd1);
    end
    prev_wr_b = wr_en_b;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
    exp_addr   = sel ? 14'h3FFE : 14'h0000;
    lo_pending = 1'b0;
    done_cnt_a = 0;
    done_cnt_b = 0;
  endtask

  // Drive n pixels first, first+1, ...; a finished pair is pushed as expected write
  task automatic send(input logic [7:0] first, input int n, input bit toggle);
    int  i = 0;
    int  cyc = 0;
    bit  acc;
    while (i < n && cyc < 200) begin
      pix_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
      pix_data  = first + 8'(i);
      acc = pix_valid && (sel ? pix_ready_b : pix_ready_a);
      tick();
      cyc++;
      if (acc) begin
        if (!lo_pending) begin
          lo_val = pix_data;
          lo_pending = 1'b1;
        end else begin
          if (sel) q_b.push_back({exp_addr, pix_data, lo_val});
          else     q_a.push_back({exp_addr, pix_data, lo_val});
          exp_addr++;
          lo_pending = 1'b0;
        end
        i++;
      end
    end
    pix_valid = 1'b0;
    if (i < n) check("send_timeout", 32'(i), 32'(n));
  endtask

  task automatic wait_idle();
    int c = 0;
    while ((sel ? busy_b : busy_a) && c < 100) begin
      tick();
      c++;
    end
    if (sel ? busy_b : busy_a) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic check_frame_end(input string tag);
    wait_idle();
    check({tag, "_done_cnt"}, 32'(done_cnt_a), 32'd1);
    check({tag, "_word_count"}, 32'(word_count_a), 32'd4);
    check({tag, "_busy"}, 32'(busy_a), 32'd0);
    check({tag, "_queue_left"}, 32'(q_a.size()), 32'd0);
  endtask

  initial begin
    repeat (2) tick();
    rst = 1'b0;
    check("rst_pix_ready", 32'(pix_ready_a), 32'd0);
    check("rst_wr_en", 32'(wr_en_a), 32'd0);
    check("rst_wr_addr", 32'(wr_addr_a), 32'h0);
    check("rst_wr_data", 32'(wr_data_a), 32'h0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_frame_done", 32'(frame_done_a), 32'd0);
    check("rst_word_count", 32'(word_count_a), 32'd0);
    check("rst_b_wr_addr", 32'(wr_addr_b), 32'h3FFE);

    // Continuous stream
    sel = 1'b0;
    start_frame();
    send(8'h10, 8, 1'b0);
    check_frame_end("cont");

    // Valid toggling every other cycle
    start_frame();
    send(8'h10, 8, 1'b1);
    check_frame_end("toggle");

    // Abort with a latched low byte, and a competing transfer in the same cycle
    start_frame();
    send(8'hAA, 1, 1'b0);
    abort = 1'b1;
    pix_valid = 1'b1;
    pix_data = 8'hBB;
    tick();
    abort = 1'b0;
    pix_valid = 1'b0;
    check("abort_busy", 32'(busy_a), 32'd0);
    check("abort_ready", 32'(pix_ready_a), 32'd0);
    tick();
    check("abort_no_done", 32'(done_cnt_a), 32'd0);
    check("abort_word_count", 32'(word_count_a), 32'd0);
    start_frame();
    check("restart_addr", 32'(wr_addr_a), 32'h0);
    send(8'h01, 8, 1'b0);
    check_frame_end("after_abort");

    // start pulses while busy: in WRITE/GET_LO and in DONE
    start_frame();
    send(8'h20, 2, 1'b0);
    start_a = 1'b1;
    tick();
    tick();
    start_a = 1'b0;
    send(8'h22, 6, 1'b0);
    tick();
    check("done_when_start", 32'(frame_done_a), 32'd1);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check_frame_end("start_busy");
    tick();
    check("start_busy_stays_idle", 32'(busy_a), 32'd0);

    // Top of address space, no wrap
    sel = 1'b1;
    start_frame();
    send(8'h40, 4, 1'b0);
    wait_idle();
    check("top_done_cnt", 32'(done_cnt_b), 32'd1);
    check("top_wr_addr_hold", 32'(wr_addr_b), 32'h3FFF);
    check("top_word_count", 32'(word_count_b), 32'd2);
    check("top_queue_left", 32'(q_b.size()), 32'd0);

    // Reset during GET_HI of word 2
    sel = 1'b0;
    start_frame();
    send(8'h60, 3, 1'b0);
    rst = 1'b1;
    pix_valid = 1'b1;
    pix_data = 8'hEE;
    tick();
    rst = 1'b0;
    pix_valid = 1'b0;
    check("mid_rst_busy", 32'(busy_a), 32'd0);
    check("mid_rst_wr_en", 32'(wr_en_a), 32'd0);
    check("mid_rst_ready", 32'(pix_ready_a), 32'd0);
    check("mid_rst_wr_addr", 32'(wr_addr_a), 32'h0);
    check("mid_rst_wr_data", 32'(wr_data_a), 32'h0);
    check("mid_rst_word_count", 32'(word_count_a), 32'd0);
    tick();
    start_frame();
    check("rst_restart_count", 32'(word_count_a), 32'd0);
    send(8'h70, 8, 1'b0);
    check_frame_end("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
